// File: rtl/imem_prefetch_if.sv
// Bus bundle for the instruction prefetcher: the instruction-memory
// req/ack channel and the valid/ready stream towards IF/ID.
interface imem_prefetch_if #(
  parameter int N = 64
);
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic [N-1:0]  out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;

  // Prefetcher side: issues memory requests, sources the instruction stream.
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_ack, imem_rdata, out_ready
  );

  // Environment side: instruction memory plus the IF/ID consumer.
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/imem_prefetch.sv
// Instruction-fetch front end: sequential fetch with one outstanding memory
// request, a small {PC, instruction} FIFO towards IF/ID, and flush on taken
// branch. A request is only issued while a FIFO slot is guaranteed free, so an
// ack never finds the FIFO full.
module imem_prefetch #(
  parameter int             N        = 64,
  parameter int             DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [N-1:0]               redirect_pc,
  imem_prefetch_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [N-1:0]  ADDR_STEP = N'(3'd4);
  localparam logic [N-1:0]  ALIGN_MSK = {{(N-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_r;
  logic [N-1:0]    fetch_pc_r;
  logic [N-1:0]    addr_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [N+31:0]   mem_r [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   count_next_s;
  logic [N-1:0]    target_s;
  logic [N-1:0]    addr_inc_s;

  // Handshake decode: what enters and leaves the FIFO this cycle.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    count_next_s = count_r;
    target_s     = redirect_pc & ALIGN_MSK;
    addr_inc_s   = addr_r + ADDR_STEP;
    if ((state_r == REQ) && bus.imem_ack && !redirect) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((count_r != {CW{1'b0}}) && bus.out_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {addr_r, bus.imem_rdata};
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (redirect) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Fetch sequencer: request issue, back-to-back streaming, and discard of redirected requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      addr_r     <= RESET_PC;
    end else begin
      case (state_r)
        IDLE: begin
          if (redirect) begin
            fetch_pc_r <= target_s;
          end else if (count_r < FULL_CNT) begin
            addr_r  <= fetch_pc_r;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (redirect && bus.imem_ack) begin
            fetch_pc_r <= target_s;
            state_r    <= IDLE;
          end else if (redirect) begin
            fetch_pc_r <= target_s;
            state_r    <= DISCARD;
          end else if (bus.imem_ack) begin
            fetch_pc_r <= addr_inc_s;
            if (count_next_s < FULL_CNT) begin
              addr_r <= addr_inc_s;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect) begin
            fetch_pc_r <= target_s;
          end
          if (bus.imem_ack) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req              = (state_r != IDLE);
  assign bus.imem_addr             = addr_r;
  assign bus.out_valid             = (count_r != {CW{1'b0}});
  assign {bus.out_pc, bus.out_instr} = mem_r[rd_ptr_r];
  assign count                     = count_r;

endmodule

// File: tb/tb_imem_prefetch.sv
// Randomized bench for imem_prefetch. The reference model works on
// transactions: a queue of fetched PCs, the next expected fetch address, and
// the rule that any request outstanding when a branch redirects is dropped.
module tb_imem_prefetch;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          redirect;
  logic [N-1:0]  redirect_pc;
  logic [2:0]    count;

  imem_prefetch_if #(.N(N)) bus ();

  imem_prefetch #(.N(N), .DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks_cnt = 0;
  int          fail_cnt   = 0;

  logic [63:0] q[$];
  logic [63:0] next_fetch;
  logic [63:0] held_addr;
  bit          outstanding, doomed;
  int          wait_left;
  bit          prev_req, prev_redir, prev_ack, prev_push;
  int          prev_size;
  int          ready_pct, redir_pct, lat_fixed;
  bit          lat_rand;
  bit          force_redir, redir_on_ack;
  logic [63:0] force_tgt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[33:2] ^ {pc[47:32], pc[63:48]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFE0 | {59'd0, t[4:0]};
    else t = {52'd0, t[11:0]};
    return t;
  endfunction

  task automatic reset_model();
    q.delete();
    next_fetch  = 64'd0;
    outstanding = 1'b0;
    doomed      = 1'b0;
    wait_left   = 0;
    prev_req    = 1'b0;
    prev_redir  = 1'b0;
    prev_ack    = 1'b0;
    prev_push   = 1'b0;
    prev_size   = 0;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 64'd0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    reset_model();
  endtask

  // One clock: check DUT outputs against the model, drive inputs, advance the model.
  task automatic step();
    bit          ack, rdy, redir, push, pop;
    logic [63:0] tgt;
    int          sz;
    @(negedge clk);
    sz = q.size();
    check_eq("count", 64'(count), 64'(sz));
    check_eq("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    if (sz != 0) begin
      check_eq("out_pc", bus.out_pc, q[0]);
      check_eq("out_instr", 64'(bus.out_instr), 64'(instr_of(q[0])));
    end
    if (sz == DEPTH) check_eq("req_full", 64'(bus.imem_req), 64'd0);
    if (prev_ack) check_eq("req_after_ack", 64'(bus.imem_req), 64'(prev_push && (sz < DEPTH)));
    else if (prev_req) check_eq("req_hold", 64'(bus.imem_req), 64'd1);
    else if (!prev_redir && (prev_size < DEPTH)) check_eq("req_issue", 64'(bus.imem_req), 64'd1);

    if (bus.imem_req) begin
      if (!outstanding) begin
        check_eq("req_addr", bus.imem_addr, next_fetch);
        held_addr   = bus.imem_addr;
        outstanding = 1'b1;
        doomed      = 1'b0;
        wait_left   = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end else begin
        check_eq("addr_hold", bus.imem_addr, held_addr);
      end
    end

    ack   = bus.imem_req && (wait_left == 0);
    rdy   = ($urandom_range(0, 99) < ready_pct);
    redir = ($urandom_range(0, 99) < redir_pct);
    tgt   = rand_target();
    if (force_redir) begin
      redir = 1'b1; tgt = force_tgt; force_redir = 1'b0;
    end
    if (redir_on_ack && ack) begin
      redir = 1'b1; tgt = force_tgt; redir_on_ack = 1'b0;
    end
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? instr_of(bus.imem_addr) : $urandom;
    bus.out_ready  = rdy;
    redirect       = redir;
    redirect_pc    = tgt;

    pop  = (sz != 0) && rdy && !redir;
    push = ack && !doomed && !redir;
    prev_req   = bus.imem_req;
    prev_redir = redir;
    prev_ack   = ack;
    prev_push  = push;
    prev_size  = sz;
    if (redir) begin
      q.delete();
      next_fetch = tgt & ~64'd3;
      if (outstanding && !ack) doomed = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(held_addr);
        next_fetch = held_addr + 64'd4;
      end
    end
    if (ack) begin
      outstanding = 1'b0;
      doomed      = 1'b0;
    end else if (bus.imem_req) begin
      wait_left--;
    end
  endtask

  initial begin
    int  maxc, first_valid;
    bit  found;
    lat_rand = 1'b0; lat_fixed = 0; ready_pct = 100; redir_pct = 0;
    force_redir = 1'b0; redir_on_ack = 1'b0; force_tgt = 64'd0;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_req", 64'(bus.imem_req), 64'd0);
    check_eq("rst_addr", bus.imem_addr, 64'd0);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);

    // Zero-wait memory, always ready: one instruction per cycle, count <= 1
    maxc = 0; first_valid = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (int'(count) > maxc) maxc = int'(count);
      if ((first_valid < 0) && bus.out_valid) first_valid = i + 1;
    end
    check_eq("a_first_valid", 64'(first_valid), 64'd2);
    check_eq("a_max_count", 64'(maxc), 64'd1);

    // Consumer stalled: FIFO fills, requests stop, then drain and resume at 16
    do_reset();
    ready_pct = 0;
    repeat (12) step();
    check_eq("b_count_full", 64'(count), 64'd4);
    check_eq("b_req_low", 64'(bus.imem_req), 64'd0);
    ready_pct = 100;
    repeat (16) step();

    // Three-cycle memory
    do_reset();
    lat_fixed = 2;
    repeat (20) step();

    // Redirect while a request is pending and entries are buffered
    do_reset();
    lat_fixed = 3; ready_pct = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if ((q.size() == 2) && outstanding && (wait_left > 0)) found = 1'b1;
    end
    check_eq("d_reached", 64'(found), 64'd1);
    force_tgt = 64'h100; force_redir = 1'b1;
    step();
    @(posedge clk); #1;
    check_eq("d_flush_count", 64'(count), 64'd0);
    check_eq("d_flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("d_discard_req", 64'(bus.imem_req), 64'd1);
    ready_pct = 100;
    repeat (20) step();

    // Redirect in the same cycle as an ack, unaligned target
    do_reset();
    lat_fixed = 1;
    repeat (6) step();
    force_tgt = 64'h203; redir_on_ack = 1'b1;
    repeat (20) step();
    check_eq("e_fired", 64'(redir_on_ack), 64'd0);

    // Random traffic
    lat_rand = 1'b1; ready_pct = 70; redir_pct = 4;
    repeat (4000) step();

    // Reset asserted mid-transaction
    lat_rand = 1'b0; lat_fixed = 1; ready_pct = 0; redir_pct = 0;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if ((count == 3'd3) && bus.imem_req) found = 1'b1;
    end
    check_eq("g_reached", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("g_req", 64'(bus.imem_req), 64'd0);
    check_eq("g_count", 64'(count), 64'd0);
    check_eq("g_valid", 64'(bus.out_valid), 64'd0);
    do_reset();
    ready_pct = 100;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule
